// File: rtl/lsu_pkg.sv
// Shared definitions for the data-side load/store unit: FSM encoding,
// RV64 access width codes, AXI constants and the alignment predicate.
package lsu_pkg;

    localparam int XLEN = 64;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_R_ADDR     = 3'd1;
    localparam logic [2:0] ST_R_DATA     = 3'd2;
    localparam logic [2:0] ST_W_ADDRDATA = 3'd3;
    localparam logic [2:0] ST_W_RESP     = 3'd4;
    localparam logic [2:0] ST_RESP       = 3'd5;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef enum logic [2:0] {
        F3_LB      = 3'b000,
        F3_LH      = 3'b001,
        F3_LW      = 3'b010,
        F3_LD      = 3'b011,
        F3_LBU     = 3'b100,
        F3_LHU     = 3'b101,
        F3_LWU     = 3'b110,
        F3_ILLEGAL = 3'b111
    } funct3_e;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
    localparam logic [2:0] AXI_SIZE_8B   = 3'd3;

    // True when the byte offset is not a multiple of the access size.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] offset);
        logic mis;
        case (size)
            SZ_B:    mis = 1'b0;
            SZ_H:    mis = offset[0];
            SZ_W:    mis = |offset[1:0];
            default: mis = |offset;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Bundle of the execute-side request, writeback result and the AXI data
// channels owned by the load/store unit.
interface lsu_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
);
    logic                    ex_valid;
    logic                    ex_ready;
    logic                    ex_load;
    logic                    ex_store;
    logic [2:0]              ex_funct3;
    logic [ADDR_WIDTH-1:0]   ex_addr;
    logic [DATA_WIDTH-1:0]   ex_wdata;
    logic                    wb_valid;
    logic [DATA_WIDTH-1:0]   wb_data;
    logic                    wb_err;
    logic [ADDR_WIDTH-1:0]   m_axi_araddr;
    logic [2:0]              m_axi_arsize;
    logic                    m_axi_arvalid;
    logic                    m_axi_arready;
    logic [DATA_WIDTH-1:0]   m_axi_rdata;
    logic [1:0]              m_axi_rresp;
    logic                    m_axi_rvalid;
    logic                    m_axi_rready;
    logic [ADDR_WIDTH-1:0]   m_axi_awaddr;
    logic [2:0]              m_axi_awsize;
    logic                    m_axi_awvalid;
    logic                    m_axi_awready;
    logic [DATA_WIDTH-1:0]   m_axi_wdata;
    logic [DATA_WIDTH/8-1:0] m_axi_wstrb;
    logic                    m_axi_wvalid;
    logic                    m_axi_wready;
    logic [1:0]              m_axi_bresp;
    logic                    m_axi_bvalid;
    logic                    m_axi_bready;

    modport master (
        input  ex_valid, ex_load, ex_store, ex_funct3, ex_addr, ex_wdata,
        input  m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid,
        input  m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid,
        output ex_ready, wb_valid, wb_data, wb_err,
        output m_axi_araddr, m_axi_arsize, m_axi_arvalid, m_axi_rready,
        output m_axi_awaddr, m_axi_awsize, m_axi_awvalid,
        output m_axi_wdata, m_axi_wstrb, m_axi_wvalid, m_axi_bready
    );

    modport slave (
        output ex_valid, ex_load, ex_store, ex_funct3, ex_addr, ex_wdata,
        output m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid,
        output m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid,
        input  ex_ready, wb_valid, wb_data, wb_err,
        input  m_axi_araddr, m_axi_arsize, m_axi_arvalid, m_axi_rready,
        input  m_axi_awaddr, m_axi_awsize, m_axi_awvalid,
        input  m_axi_wdata, m_axi_wstrb, m_axi_wvalid, m_axi_bready
    );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering: store data/strobe placement and load lane extraction
// with sign or zero extension. Purely combinational.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [2:0]      offset,
    input  logic [XLEN-1:0] store_data,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] wdata,
    output logic [7:0]      wstrb,
    output logic [XLEN-1:0] load_data
);
    logic [5:0]      shamt_s;
    logic [XLEN-1:0] lane_s;

    // Lane shift, strobe and load extension.
    always_comb begin
        shamt_s = {offset, 3'b000};
        lane_s  = rdata >> shamt_s;
        wdata   = store_data << shamt_s;
        case (funct3[1:0])
            SZ_B:    wstrb = 8'h01 << offset;
            SZ_H:    wstrb = 8'h03 << offset;
            SZ_W:    wstrb = 8'h0F << offset;
            default: wstrb = 8'hFF << offset;
        endcase
        case (funct3)
            F3_LB:   load_data = {{56{lane_s[7]}}, lane_s[7:0]};
            F3_LH:   load_data = {{48{lane_s[15]}}, lane_s[15:0]};
            F3_LW:   load_data = {{32{lane_s[31]}}, lane_s[31:0]};
            F3_LD:   load_data = lane_s;
            F3_LBU:  load_data = {56'd0, lane_s[7:0]};
            F3_LHU:  load_data = {48'd0, lane_s[15:0]};
            F3_LWU:  load_data = {32'd0, lane_s[31:0]};
            default: load_data = {XLEN{1'b0}};
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// Memory stage: turns one accepted execute op into a single-beat AXI read or
// write (or a pass-through) and emits one registered writeback result.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
) (
    input logic   clk,
    input logic   reset,
    lsu_if.master bus
);
    logic [2:0]              state_r;
    logic                    ex_ready_r, arvalid_r, rready_r, awvalid_r, wvalid_r, bready_r;
    logic                    wb_valid_r, wb_err_r;
    logic [ADDR_WIDTH-1:0]   araddr_r, awaddr_r;
    logic [DATA_WIDTH-1:0]   wdata_r, wb_data_r;
    logic [DATA_WIDTH/8-1:0] wstrb_r;
    logic [2:0]              funct3_r, offset_r;

    logic                    accept_s, pass_s, mis_s, load_ok_s, store_ok_s, aw_fin_s, w_fin_s;
    logic [2:0]              align_f3_s, align_off_s;
    logic [ADDR_WIDTH-1:0]   line_addr_s;
    logic [DATA_WIDTH-1:0]   st_lane_s, ld_ext_s;
    logic [7:0]              strb_s;

    // Op decode and handshake completion terms.
    always_comb begin
        accept_s    = bus.ex_valid & ex_ready_r;
        pass_s      = ~bus.ex_load & ~bus.ex_store;
        mis_s       = is_misaligned(bus.ex_funct3[1:0], bus.ex_addr[2:0]);
        load_ok_s   = bus.ex_load & ~bus.ex_store & (bus.ex_funct3 != F3_ILLEGAL) & ~mis_s;
        store_ok_s  = bus.ex_store & ~bus.ex_load & ~bus.ex_funct3[2] & ~mis_s;
        line_addr_s = {bus.ex_addr[ADDR_WIDTH-1:3], 3'b000};
        aw_fin_s    = ~awvalid_r | bus.m_axi_awready;
        w_fin_s     = ~wvalid_r | bus.m_axi_wready;
        // Stores are steered from the live request; loads extend using the captured op.
        if (state_r == ST_IDLE) begin
            align_f3_s  = bus.ex_funct3;
            align_off_s = bus.ex_addr[2:0];
        end else begin
            align_f3_s  = funct3_r;
            align_off_s = offset_r;
        end
    end

    lsu_align u_align (
        .funct3     (align_f3_s),
        .offset     (align_off_s),
        .store_data (bus.ex_wdata),
        .rdata      (bus.m_axi_rdata),
        .wdata      (st_lane_s),
        .wstrb      (strb_s),
        .load_data  (ld_ext_s)
    );

    // Transaction FSM and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            ex_ready_r <= 1'b0;
            arvalid_r  <= 1'b0;
            rready_r   <= 1'b0;
            awvalid_r  <= 1'b0;
            wvalid_r   <= 1'b0;
            bready_r   <= 1'b0;
            wb_valid_r <= 1'b0;
            wb_err_r   <= 1'b0;
            wb_data_r  <= '0;
            araddr_r   <= '0;
            awaddr_r   <= '0;
            wdata_r    <= '0;
            wstrb_r    <= '0;
            funct3_r   <= 3'd0;
            offset_r   <= 3'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        ex_ready_r <= 1'b0;
                        funct3_r   <= bus.ex_funct3;
                        offset_r   <= bus.ex_addr[2:0];
                        if (load_ok_s) begin
                            state_r   <= ST_R_ADDR;
                            arvalid_r <= 1'b1;
                            araddr_r  <= line_addr_s;
                        end else if (store_ok_s) begin
                            state_r   <= ST_W_ADDRDATA;
                            awvalid_r <= 1'b1;
                            wvalid_r  <= 1'b1;
                            awaddr_r  <= line_addr_s;
                            wdata_r   <= st_lane_s;
                            wstrb_r   <= strb_s;
                        end else begin
                            // Pass-through and every rejected op finish without touching the bus.
                            state_r    <= ST_RESP;
                            wb_valid_r <= 1'b1;
                            wb_err_r   <= ~pass_s;
                            wb_data_r  <= pass_s ? DATA_WIDTH'(bus.ex_addr) : '0;
                        end
                    end else begin
                        ex_ready_r <= 1'b1;
                    end
                end
                ST_R_ADDR: begin
                    if (bus.m_axi_arready) begin
                        arvalid_r <= 1'b0;
                        rready_r  <= 1'b1;
                        state_r   <= ST_R_DATA;
                    end
                end
                ST_R_DATA: begin
                    if (bus.m_axi_rvalid) begin
                        rready_r   <= 1'b0;
                        state_r    <= ST_RESP;
                        wb_valid_r <= 1'b1;
                        wb_err_r   <= (bus.m_axi_rresp != AXI_RESP_OKAY);
                        wb_data_r  <= (bus.m_axi_rresp != AXI_RESP_OKAY) ? '0 : ld_ext_s;
                    end
                end
                ST_W_ADDRDATA: begin
                    if (bus.m_axi_awready) awvalid_r <= 1'b0;
                    if (bus.m_axi_wready)  wvalid_r  <= 1'b0;
                    if (aw_fin_s && w_fin_s) begin
                        state_r  <= ST_W_RESP;
                        bready_r <= 1'b1;
                    end
                end
                ST_W_RESP: begin
                    if (bus.m_axi_bvalid) begin
                        bready_r   <= 1'b0;
                        state_r    <= ST_RESP;
                        wb_valid_r <= 1'b1;
                        wb_err_r   <= (bus.m_axi_bresp != AXI_RESP_OKAY);
                        wb_data_r  <= '0;
                    end
                end
                ST_RESP: begin
                    wb_valid_r <= 1'b0;
                    ex_ready_r <= 1'b1;
                    state_r    <= ST_IDLE;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    ex_ready_r <= 1'b0;
                    arvalid_r  <= 1'b0;
                    rready_r   <= 1'b0;
                    awvalid_r  <= 1'b0;
                    wvalid_r   <= 1'b0;
                    bready_r   <= 1'b0;
                    wb_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ex_ready      = ex_ready_r;
    assign bus.wb_valid      = wb_valid_r;
    assign bus.wb_data       = wb_data_r;
    assign bus.wb_err        = wb_err_r;
    assign bus.m_axi_araddr  = araddr_r;
    assign bus.m_axi_arsize  = AXI_SIZE_8B;
    assign bus.m_axi_arvalid = arvalid_r;
    assign bus.m_axi_rready  = rready_r;
    assign bus.m_axi_awaddr  = awaddr_r;
    assign bus.m_axi_awsize  = AXI_SIZE_8B;
    assign bus.m_axi_awvalid = awvalid_r;
    assign bus.m_axi_wdata   = wdata_r;
    assign bus.m_axi_wstrb   = wstrb_r;
    assign bus.m_axi_wvalid  = wvalid_r;
    assign bus.m_axi_bready  = bready_r;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, reset-abort sequence and
// randomized ops checked against a byte-level reference model.
module tb_load_store_unit;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    lsu_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) bus ();

    load_store_unit #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [63:0] addr;
        logic [63:0] wd;
        logic [63:0] rd;
        logic [1:0]  rresp;
        logic [1:0]  bresp;
        int          ard;
        int          rdl;
        int          awd;
        int          wdl;
        int          bdl;
        logic [63:0] e_data;
        logic        e_err;
        int          e_lat;
        int          e_kind;   // 0 no bus, 1 read, 2 write
        logic [63:0] e_ax;
        logic [63:0] e_wdata;
        logic [7:0]  e_strb;
    } vec_t;

    vec_t tbl[20];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    function automatic vec_t vin(input logic ld, input logic st, input logic [2:0] f3,
                                 input logic [63:0] addr, input logic [63:0] wd, input logic [63:0] rd,
                                 input logic [1:0] rresp, input logic [1:0] bresp,
                                 input int ard, input int rdl, input int awd, input int wdl, input int bdl);
        vec_t v;
        v = '0;
        v.ld = ld; v.st = st; v.f3 = f3; v.addr = addr; v.wd = wd; v.rd = rd;
        v.rresp = rresp; v.bresp = bresp;
        v.ard = ard; v.rdl = rdl; v.awd = awd; v.wdl = wdl; v.bdl = bdl;
        return v;
    endfunction

    function automatic vec_t vexp(input vec_t vi, input logic [63:0] data, input logic err, input int lat,
                                  input int kind, input logic [63:0] ax, input logic [63:0] wdat,
                                  input logic [7:0] strb);
        vec_t v;
        v = vi;
        v.e_data = data; v.e_err = err; v.e_lat = lat; v.e_kind = kind;
        v.e_ax = ax; v.e_wdata = wdat; v.e_strb = strb;
        return v;
    endfunction

    // Reference: byte arithmetic straight from the RV64 load/store rules.
    function automatic vec_t model(input vec_t vi);
        vec_t        v;
        int          bytes, off;
        logic        pass, bad;
        logic [63:0] mask, val;
        v = vi;
        bytes = 1 << vi.f3[1:0];
        off = int'(vi.addr[2:0]);
        pass = !vi.ld && !vi.st;
        bad = (vi.ld && vi.st) || (vi.ld && vi.f3 == 3'd7) || (vi.st && vi.f3[2]) ||
              (!pass && (off % bytes) != 0);
        v.e_data = '0; v.e_err = 1'b0; v.e_lat = 1; v.e_kind = 0;
        v.e_ax = '0; v.e_wdata = '0; v.e_strb = '0;
        if (pass) begin
            v.e_data = vi.addr;
        end else if (bad) begin
            v.e_err = 1'b1;
        end else if (vi.ld) begin
            v.e_kind = 1;
            v.e_ax = vi.addr & ~64'h7;
            v.e_lat = 3 + vi.ard + vi.rdl;
            mask = (bytes == 8) ? ~64'd0 : ((64'd1 << (8 * bytes)) - 64'd1);
            val = (vi.rd >> (8 * off)) & mask;
            if (!vi.f3[2] && val[8 * bytes - 1]) val = val | ~mask;
            if (vi.rresp != 2'b00) v.e_err = 1'b1;
            else v.e_data = val;
        end else begin
            v.e_kind = 2;
            v.e_ax = vi.addr & ~64'h7;
            v.e_lat = ((vi.awd > vi.wdl) ? vi.awd : vi.wdl) + 3 + vi.bdl;
            v.e_wdata = vi.wd << (8 * off);
            v.e_strb = 8'(((1 << bytes) - 1) << off);
            v.e_err = (vi.bresp != 2'b00);
        end
        return v;
    endfunction

    task automatic idle_inputs();
        bus.ex_valid = 1'b0; bus.ex_load = 1'b0; bus.ex_store = 1'b0;
        bus.ex_funct3 = 3'd0; bus.ex_addr = '0; bus.ex_wdata = '0;
        bus.m_axi_arready = 1'b0; bus.m_axi_rdata = '0; bus.m_axi_rresp = 2'b00; bus.m_axi_rvalid = 1'b0;
        bus.m_axi_awready = 1'b0; bus.m_axi_wready = 1'b0; bus.m_axi_bresp = 2'b00; bus.m_axi_bvalid = 1'b0;
    endtask

    // Issue one op, act as a slave with the vector's wait states, check the result.
    task automatic do_op(input vec_t v, input int idx);
        int          n, ar_n, r_n, aw_n, w_n, b_n, unstable, lat;
        logic        got, e;
        logic [63:0] d, ar_a, aw_a, w_d;
        logic [7:0]  w_s;
        ar_n = 0; r_n = 0; aw_n = 0; w_n = 0; b_n = 0; unstable = 0; lat = 0;
        got = 1'b0; e = 1'b0; d = '0; ar_a = '0; aw_a = '0; w_d = '0; w_s = '0;
        n = 0;
        while (bus.ex_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk($sformatf("v%0d ex_ready", idx), 64'(bus.ex_ready), 64'd1);
        bus.ex_valid = 1'b1; bus.ex_load = v.ld; bus.ex_store = v.st;
        bus.ex_funct3 = v.f3; bus.ex_addr = v.addr; bus.ex_wdata = v.wd;
        @(posedge clk); #1;
        bus.ex_valid = 1'b0; bus.ex_load = 1'b0; bus.ex_store = 1'b0;
        n = 1;
        while (!got && n <= 100) begin
            if (bus.wb_valid === 1'b1) begin
                got = 1'b1; d = bus.wb_data; e = bus.wb_err; lat = n;
            end else begin
                if (bus.m_axi_arvalid === 1'b1) begin
                    if (ar_n == 0) ar_a = bus.m_axi_araddr;
                    else if (bus.m_axi_araddr !== ar_a) unstable++;
                    ar_n++;
                    bus.m_axi_arready = (ar_n > v.ard);
                end else bus.m_axi_arready = 1'b0;
                if (bus.m_axi_rready === 1'b1) begin
                    r_n++;
                    bus.m_axi_rvalid = (r_n > v.rdl);
                    bus.m_axi_rdata = v.rd; bus.m_axi_rresp = v.rresp;
                end else bus.m_axi_rvalid = 1'b0;
                if (bus.m_axi_awvalid === 1'b1) begin
                    if (aw_n == 0) aw_a = bus.m_axi_awaddr;
                    else if (bus.m_axi_awaddr !== aw_a) unstable++;
                    aw_n++;
                    bus.m_axi_awready = (aw_n > v.awd);
                end else bus.m_axi_awready = 1'b0;
                if (bus.m_axi_wvalid === 1'b1) begin
                    if (w_n == 0) begin w_d = bus.m_axi_wdata; w_s = bus.m_axi_wstrb; end
                    else if (bus.m_axi_wdata !== w_d || bus.m_axi_wstrb !== w_s) unstable++;
                    w_n++;
                    bus.m_axi_wready = (w_n > v.wdl);
                end else bus.m_axi_wready = 1'b0;
                if (bus.m_axi_bready === 1'b1) begin
                    b_n++;
                    bus.m_axi_bvalid = (b_n > v.bdl);
                    bus.m_axi_bresp = v.bresp;
                end else bus.m_axi_bvalid = 1'b0;
                @(posedge clk); #1; n++;
            end
        end
        idle_inputs();
        chk($sformatf("v%0d wb_valid_seen", idx), 64'(got), 64'd1);
        chk($sformatf("v%0d wb_data", idx), d, v.e_data);
        chk($sformatf("v%0d wb_err", idx), 64'(e), 64'(v.e_err));
        chk($sformatf("v%0d latency", idx), 64'(lat), 64'(v.e_lat));
        chk($sformatf("v%0d ar_cycles", idx), 64'(ar_n), (v.e_kind == 1) ? 64'(v.ard + 1) : 64'd0);
        chk($sformatf("v%0d aw_cycles", idx), 64'(aw_n), (v.e_kind == 2) ? 64'(v.awd + 1) : 64'd0);
        chk($sformatf("v%0d w_cycles", idx), 64'(w_n), (v.e_kind == 2) ? 64'(v.wdl + 1) : 64'd0);
        chk($sformatf("v%0d stable", idx), 64'(unstable), 64'd0);
        if (v.e_kind == 1) chk($sformatf("v%0d araddr", idx), ar_a, v.e_ax);
        if (v.e_kind == 2) begin
            chk($sformatf("v%0d awaddr", idx), aw_a, v.e_ax);
            chk($sformatf("v%0d wdata", idx), w_d, v.e_wdata);
            chk($sformatf("v%0d wstrb", idx), 64'(w_s), 64'(v.e_strb));
        end
        if (got) begin
            @(posedge clk); #1;
            chk($sformatf("v%0d wb_pulse", idx), 64'(bus.wb_valid), 64'd0);
            chk($sformatf("v%0d back_idle", idx), 64'(bus.ex_ready), 64'd1);
        end
    endtask

    initial begin
        vec_t v;
        int   k, n;
        logic [2:0] m;
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst ex_ready", 64'(bus.ex_ready), 64'd0);
        chk("rst wb_valid", 64'(bus.wb_valid), 64'd0);
        chk("rst arvalid", 64'(bus.m_axi_arvalid), 64'd0);
        chk("rst rready", 64'(bus.m_axi_rready), 64'd0);
        chk("rst awvalid", 64'(bus.m_axi_awvalid), 64'd0);
        chk("rst wvalid", 64'(bus.m_axi_wvalid), 64'd0);
        chk("rst bready", 64'(bus.m_axi_bready), 64'd0);
        chk("rst wb_data", bus.wb_data, 64'd0);
        chk("rst wb_err", 64'(bus.wb_err), 64'd0);
        chk("rst araddr", bus.m_axi_araddr, 64'd0);
        chk("rst awaddr", bus.m_axi_awaddr, 64'd0);
        chk("rst wdata", bus.m_axi_wdata, 64'd0);
        chk("rst wstrb", 64'(bus.m_axi_wstrb), 64'd0);
        chk("arsize", 64'(bus.m_axi_arsize), 64'd3);
        chk("awsize", 64'(bus.m_axi_awsize), 64'd3);
        reset = 1'b0;

        tbl[0]  = vexp(vin(1, 0, 3'd0, 64'h1003, 64'd0, 64'h0000_0000_8000_0000, 2'd0, 2'd0, 0, 0, 0, 0, 0),
                       64'hFFFF_FFFF_FFFF_FF80, 1'b0, 3, 1, 64'h1000, 64'd0, 8'h00);
        tbl[1]  = vexp(vin(0, 1, 3'd1, 64'h2006, 64'hBEEF, 64'd0, 2'd0, 2'd0, 0, 0, 0, 0, 0),
                       64'd0, 1'b0, 3, 2, 64'h2000, 64'hBEEF_0000_0000_0000, 8'hC0);
        tbl[2]  = vexp(vin(1, 0, 3'd2, 64'h1002, 64'd0, 64'd0, 2'd0, 2'd0, 0, 0, 0, 0, 0),
                       64'd0, 1'b1, 1, 0, 64'd0, 64'd0, 8'h00);
        tbl[3]  = vexp(vin(1, 0, 3'd3, 64'h3000, 64'd0, 64'h1111, 2'd2, 2'd0, 0, 0, 0, 0, 0),
                       64'd0, 1'b1, 3, 1, 64'h3000, 64'd0, 8'h00);
        tbl[4]  = vexp(vin(0, 0, 3'd0, 64'h1234, 64'd0, 64'd0, 2'd0, 2'd0, 0, 0, 0, 0, 0),
                       64'h1234, 1'b0, 1, 0, 64'd0, 64'd0, 8'h00);
        tbl[5]  = vexp(vin(1, 0, 3'd4, 64'h1003, 64'd0, 64'h0000_0000_8000_0000, 2'd0, 2'd0, 0, 0, 0, 0, 0),
                       64'h80, 1'b0, 3, 1, 64'h1000, 64'd0, 8'h00);
        tbl[6]  = vexp(vin(1, 0, 3'd2, 64'h1004, 64'd0, 64'h8765_4321_0000_0000, 2'd0, 2'd0, 0, 0, 0, 0, 0),
                       64'hFFFF_FFFF_8765_4321, 1'b0, 3, 1, 64'h1000, 64'd0, 8'h00);
        tbl[7]  = vexp(vin(1, 0, 3'd6, 64'h1004, 64'd0, 64'h8765_4321_0000_0000, 2'd0, 2'd0, 0, 0, 0, 0, 0),
                       64'h8765_4321, 1'b0, 3, 1, 64'h1000, 64'd0, 8'h00);
        tbl[8]  = vexp(vin(1, 0, 3'd1, 64'h12, 64'd0, 64'h0000_0000_FFFE_0000, 2'd0, 2'd0, 0, 0, 0, 0, 0),
                       64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 3, 1, 64'h10, 64'd0, 8'h00);
        tbl[9]  = vexp(vin(1, 0, 3'd5, 64'h12, 64'd0, 64'h0000_0000_FFFE_0000, 2'd0, 2'd0, 0, 0, 0, 0, 0),
                       64'hFFFE, 1'b0, 3, 1, 64'h10, 64'd0, 8'h00);
        tbl[10] = vexp(vin(0, 1, 3'd3, 64'h8, 64'h0123_4567_89AB_CDEF, 64'd0, 2'd0, 2'd2, 0, 0, 0, 0, 0),
                       64'd0, 1'b1, 3, 2, 64'h8, 64'h0123_4567_89AB_CDEF, 8'hFF);
        tbl[11] = vexp(vin(0, 1, 3'd0, 64'h5, 64'hFFFF_FFFF_FFFF_FFAB, 64'd0, 2'd0, 2'd0, 0, 0, 0, 0, 0),
                       64'd0, 1'b0, 3, 2, 64'h0, 64'hFFFF_AB00_0000_0000, 8'h20);
        tbl[12] = vexp(vin(1, 0, 3'd7, 64'h0, 64'd0, 64'd0, 2'd0, 2'd0, 0, 0, 0, 0, 0),
                       64'd0, 1'b1, 1, 0, 64'd0, 64'd0, 8'h00);
        tbl[13] = vexp(vin(0, 1, 3'd5, 64'h0, 64'd0, 64'd0, 2'd0, 2'd0, 0, 0, 0, 0, 0),
                       64'd0, 1'b1, 1, 0, 64'd0, 64'd0, 8'h00);
        tbl[14] = vexp(vin(1, 1, 3'd3, 64'h0, 64'd0, 64'd0, 2'd0, 2'd0, 0, 0, 0, 0, 0),
                       64'd0, 1'b1, 1, 0, 64'd0, 64'd0, 8'h00);
        tbl[15] = vexp(vin(0, 1, 3'd2, 64'h4, 64'hDEAD_BEEF, 64'd0, 2'd0, 2'd0, 0, 0, 3, 0, 0),
                       64'd0, 1'b0, 6, 2, 64'h0, 64'hDEAD_BEEF_0000_0000, 8'hF0);
        tbl[16] = vexp(vin(1, 0, 3'd3, 64'h40, 64'd0, 64'h1122_3344_5566_7788, 2'd0, 2'd0, 2, 1, 0, 0, 0),
                       64'h1122_3344_5566_7788, 1'b0, 6, 1, 64'h40, 64'd0, 8'h00);
        tbl[17] = vexp(vin(0, 1, 3'd2, 64'h2000, 64'h1, 64'd0, 2'd0, 2'd0, 0, 0, 0, 2, 1),
                       64'd0, 1'b0, 6, 2, 64'h2000, 64'h1, 8'h0F);
        tbl[18] = vexp(vin(0, 1, 3'd3, 64'h2004, 64'h5, 64'd0, 2'd0, 2'd0, 0, 0, 0, 0, 0),
                       64'd0, 1'b1, 1, 0, 64'd0, 64'd0, 8'h00);
        tbl[19] = vexp(vin(0, 0, 3'd3, 64'hFFFF_0000_DEAD_BEEF, 64'd0, 64'd0, 2'd0, 2'd0, 0, 0, 0, 0, 0),
                       64'hFFFF_0000_DEAD_BEEF, 1'b0, 1, 0, 64'd0, 64'd0, 8'h00);

        for (int i = 0; i < 20; i++) do_op(tbl[i], i);

        // Reset while waiting in R_DATA aborts the load and drops rready.
        n = 0;
        while (bus.ex_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        bus.ex_valid = 1'b1; bus.ex_load = 1'b1; bus.ex_funct3 = 3'd3; bus.ex_addr = 64'h100;
        @(posedge clk); #1;
        idle_inputs();
        chk("abort arvalid_up", 64'(bus.m_axi_arvalid), 64'd1);
        bus.m_axi_arready = 1'b1;
        @(posedge clk); #1;
        bus.m_axi_arready = 1'b0;
        chk("abort in_r_data", 64'(bus.m_axi_rready), 64'd1);
        reset = 1'b1;
        #1;
        chk("abort rready", 64'(bus.m_axi_rready), 64'd0);
        chk("abort arvalid", 64'(bus.m_axi_arvalid), 64'd0);
        chk("abort wb_valid", 64'(bus.wb_valid), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        do_op(tbl[4], 100);

        for (int i = 0; i < 150; i++) begin
            v = '0;
            k = $urandom_range(0, 9);
            v.ld = (k >= 2 && k <= 5) || k == 9;
            v.st = (k >= 6);
            v.f3 = 3'($urandom_range(0, 7));
            v.addr = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) begin
                m = 3'((4'd1 << v.f3[1:0]) - 4'd1);
                v.addr[2:0] = v.addr[2:0] & ~m;
            end
            v.wd = {$urandom, $urandom};
            v.rd = {$urandom, $urandom};
            v.rresp = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            v.bresp = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            v.ard = $urandom_range(0, 3); v.rdl = $urandom_range(0, 3);
            v.awd = $urandom_range(0, 3); v.wdl = $urandom_range(0, 3);
            v.bdl = $urandom_range(0, 3);
            do_op(model(v), 200 + i);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
